// File: rtl/gpr_mp_if.sv
// Bus bundle for gpr_mp: read ports, both writeback ports, load reservations
// and scoreboard status.
`timescale 1ns/1ps
interface gpr_mp_if #(
   parameter int W  = 32,
   parameter int AW = 5,
   parameter int NR = 2
);
   logic [NR*AW-1:0] ra;
   logic [NR*W-1:0]  rdata;
   logic [NR-1:0]    rbusy;
   logic [AW-1:0]    wa0;
   logic [W-1:0]     wd0;
   logic             we0;
   logic [AW-1:0]    wa1;
   logic [W-1:0]     wd1;
   logic             we1;
   logic             rsv_en;
   logic [AW-1:0]    rsv_addr;
   logic [AW:0]      pend_cnt;
   logic             sb_err;

   modport master (
      output ra, wa0, wd0, we0, wa1, wd1, we1, rsv_en, rsv_addr,
      input  rdata, rbusy, pend_cnt, sb_err
   );

   modport slave (
      input  ra, wa0, wd0, we0, wa1, wd1, we1, rsv_en, rsv_addr,
      output rdata, rbusy, pend_cnt, sb_err
   );
endinterface

// File: rtl/gpr_mp.sv
// Two-write / NR-read register file with writeback forwarding and a
// scoreboard of registers still waiting on load data.
`timescale 1ns/1ps
module gpr_mp #(
   parameter int W        = 32,
   parameter int AW       = 5,
   parameter int NR       = 2,
   parameter int ZERO_REG = 1
) (
   input  logic     clk,
   input  logic     rst,
   gpr_mp_if.slave  bus
);
   localparam int DEPTH = 2**AW;
   localparam bit ZR    = (ZERO_REG != 0);

   logic [W-1:0]     mem [DEPTH];
   logic [DEPTH-1:0] pending;
   logic [DEPTH-1:0] pend_nxt;
   logic [AW:0]      pend_cnt_q;
   logic             sb_err_q;

   logic wr0_ok, wr1_ok, rsv_ok, rsv_rel_same, inc, dec, err_now;

   always_comb begin
      wr0_ok       = bus.we0 && !(ZR && bus.wa0 == '0);
      wr1_ok       = bus.we1 && !(ZR && bus.wa1 == '0);
      rsv_ok       = bus.rsv_en && !(ZR && bus.rsv_addr == '0);
      rsv_rel_same = bus.we1 && bus.wa1 == bus.rsv_addr;
      inc          = rsv_ok && !pending[bus.rsv_addr];
      dec          = bus.we1 && pending[bus.wa1] && !(rsv_ok && rsv_rel_same);
      err_now      = (rsv_ok && pending[bus.rsv_addr] && !rsv_rel_same)
                  || (bus.we0 && pending[bus.wa0])
                  || (bus.we1 && !pending[bus.wa1]);
   end

   // a reservation landing on the address being released keeps it pending
   always_comb begin
      pend_nxt = pending;
      if (bus.we1) pend_nxt[bus.wa1] = 1'b0;
      if (rsv_ok)  pend_nxt[bus.rsv_addr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         pending    <= '0;
         pend_cnt_q <= '0;
         sb_err_q   <= 1'b0;
      end else begin
         if (wr0_ok) mem[bus.wa0] <= bus.wd0;
         if (wr1_ok) mem[bus.wa1] <= bus.wd1;
         pending    <= pend_nxt;
         pend_cnt_q <= pend_cnt_q + (AW+1)'(inc) - (AW+1)'(dec);
         if (err_now) sb_err_q <= 1'b1;
      end
   end

   logic [NR*W-1:0] rdata_c;
   logic [NR-1:0]   rbusy_c;

   always_comb begin : rd_ports
      logic [AW-1:0] ra_i;
      rdata_c = '0;
      rbusy_c = '0;
      ra_i    = '0;
      for (int i = 0; i < NR; i++) begin
         ra_i = bus.ra[i*AW +: AW];
         if (!rst || (ZR && ra_i == '0))
            rdata_c[i*W +: W] = '0;
         else if (bus.we1 && bus.wa1 == ra_i)
            rdata_c[i*W +: W] = bus.wd1;
         else if (bus.we0 && bus.wa0 == ra_i)
            rdata_c[i*W +: W] = bus.wd0;
         else
            rdata_c[i*W +: W] = mem[ra_i];
         rbusy_c[i] = rst && pending[ra_i] && !(bus.we1 && bus.wa1 == ra_i);
      end
   end

   assign bus.rdata    = rdata_c;
   assign bus.rbusy    = rbusy_c;
   assign bus.pend_cnt = pend_cnt_q;
   assign bus.sb_err   = sb_err_q;
endmodule

// File: tb/tb_gpr_mp.sv
// Bench for gpr_mp: directed scoreboard scenarios with literal expectations,
// then randomized traffic checked every cycle against an array-based model.
`timescale 1ns/1ps
module tb_gpr_mp;
   localparam int W     = 32;
   localparam int AW    = 5;
   localparam int NR    = 2;
   localparam int DEPTH = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   gpr_mp_if #(.W(W), .AW(AW), .NR(NR)) bus();

   gpr_mp #(.W(W), .AW(AW), .NR(NR), .ZERO_REG(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   logic [AW-1:0] rav [NR];
   assign bus.ra = {rav[1], rav[0]};

   int n_vec = 0;
   int n_err = 0;

   // reference state: plain arrays updated by the architectural rules
   logic [W-1:0]     m_mem [DEPTH];
   logic [DEPTH-1:0] m_pend = '0;
   bit               m_err = 1'b0;
   bit               m_valid = 1'b0;

   always @(posedge clk) begin : model
      logic [DEPTH-1:0] old;
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
         m_pend  = '0;
         m_err   = 1'b0;
         m_valid = 1'b1;
      end else begin
         old = m_pend;
         if (bus.we0 && old[bus.wa0]) m_err = 1'b1;
         if (bus.we1) begin
            if (!old[bus.wa1]) m_err = 1'b1;
            m_pend[bus.wa1] = 1'b0;
         end
         if (bus.rsv_en && bus.rsv_addr != 0) begin
            if (old[bus.rsv_addr] && !(bus.we1 && bus.wa1 == bus.rsv_addr)) m_err = 1'b1;
            m_pend[bus.rsv_addr] = 1'b1;
         end
         if (bus.we0 && bus.wa0 != 0) m_mem[bus.wa0] = bus.wd0;
         if (bus.we1 && bus.wa1 != 0) m_mem[bus.wa1] = bus.wd1;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      logic [W-1:0] ed;
      logic         eb;
      logic [AW-1:0] a;
      if (!m_valid) return;
      for (int p = 0; p < NR; p++) begin
         a = rav[p];
         if (!rst || a == 0)                ed = '0;
         else if (bus.we1 && bus.wa1 == a)  ed = bus.wd1;
         else if (bus.we0 && bus.wa0 == a)  ed = bus.wd0;
         else                               ed = m_mem[a];
         eb = rst && m_pend[a] && !(bus.we1 && bus.wa1 == a);
         chk($sformatf("rdata[%0d]", p), 64'(bus.rdata[p*W +: W]), 64'(ed));
         chk($sformatf("rbusy[%0d]", p), 64'(bus.rbusy[p]), 64'(eb));
      end
      chk("pend_cnt", 64'(bus.pend_cnt), 64'($countones(m_pend)));
      chk("sb_err", 64'(bus.sb_err), 64'(m_err));
   endtask

   task automatic tick();
      #3;
      compare_all();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.we0 = 1'b0; bus.wa0 = '0; bus.wd0 = '0;
      bus.we1 = 1'b0; bus.wa1 = '0; bus.wd1 = '0;
      bus.rsv_en = 1'b0; bus.rsv_addr = '0;
   endtask

   task automatic reserve(input logic [AW-1:0] a);
      bus.rsv_en = 1'b1; bus.rsv_addr = a;
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 5));
      return AW'($urandom);
   endfunction

   initial begin
      rav[0] = '0; rav[1] = '0;
      idle();
      @(posedge clk); #1;
      tick(); tick();
      rst = 1'b1;

      // everything reads zero after reset
      for (int a = 0; a < DEPTH; a++) begin
         rav[0] = AW'(a); rav[1] = AW'(DEPTH - 1 - a);
         #1;
         chk("rst_rd0", 64'(bus.rdata[W-1:0]), 64'h0);
         chk("rst_rd1", 64'(bus.rdata[2*W-1:W]), 64'h0);
         tick();
      end

      // forwarding from port 0, then from storage
      bus.we0 = 1'b1; bus.wa0 = 5'd5; bus.wd0 = 32'hDEADBEEF; rav[0] = 5'd5;
      #1 chk("fwd0", 64'(bus.rdata[W-1:0]), 64'hDEADBEEF);
      tick(); idle();
      #1 chk("mem5", 64'(bus.rdata[W-1:0]), 64'hDEADBEEF);

      // both ports to 7: port 1 wins; load to non-pending flags sb_err
      bus.we0 = 1'b1; bus.wa0 = 5'd7; bus.wd0 = 32'd1;
      bus.we1 = 1'b1; bus.wa1 = 5'd7; bus.wd1 = 32'd2; rav[0] = 5'd7;
      #1 chk("fwd_both", 64'(bus.rdata[W-1:0]), 64'd2);
      tick(); idle();
      #1 chk("mem7", 64'(bus.rdata[W-1:0]), 64'd2);
      chk("err_nonpend", 64'(bus.sb_err), 64'd1);
      rst = 1'b0; tick(); rst = 1'b1;

      // zero register ignores writes and reservations
      bus.we0 = 1'b1; bus.wa0 = 5'd0; bus.wd0 = 32'h1234; rav[0] = 5'd0;
      #1 chk("r0_fwd", 64'(bus.rdata[W-1:0]), 64'h0);
      tick(); idle();
      #1 chk("r0_mem", 64'(bus.rdata[W-1:0]), 64'h0);
      chk("r0_cnt", 64'(bus.pend_cnt), 64'd0);
      reserve(5'd0);
      tick(); idle();
      #1 chk("r0_busy", 64'(bus.rbusy[0]), 64'd0);
      chk("r0_rsv_cnt", 64'(bus.pend_cnt), 64'd0);

      // reserve then release 9
      reserve(5'd9);
      tick(); idle(); rav[0] = 5'd9;
      #1 chk("busy9", 64'(bus.rbusy[0]), 64'd1);
      chk("cnt9", 64'(bus.pend_cnt), 64'd1);
      bus.we1 = 1'b1; bus.wa1 = 5'd9; bus.wd1 = 32'h55;
      #1 chk("rel9_busy", 64'(bus.rbusy[0]), 64'd0);
      chk("rel9_data", 64'(bus.rdata[W-1:0]), 64'h55);
      tick(); idle();
      #1 chk("rel9_cnt", 64'(bus.pend_cnt), 64'd0);
      chk("rel9_err", 64'(bus.sb_err), 64'd0);

      // double reserve, reserve+release same cycle, then reset
      reserve(5'd3); tick();
      reserve(5'd3); tick(); idle();
      #1 chk("dup_err", 64'(bus.sb_err), 64'd1);
      chk("dup_cnt", 64'(bus.pend_cnt), 64'd1);
      reserve(5'd4); bus.we1 = 1'b1; bus.wa1 = 5'd4; bus.wd1 = 32'hAA;
      tick(); idle(); rav[1] = 5'd4;
      #1 chk("rr_cnt", 64'(bus.pend_cnt), 64'd2);
      chk("rr_busy", 64'(bus.rbusy[1]), 64'd1);
      rst = 1'b0;
      #1 chk("rstlo_busy", 64'(bus.rbusy[1]), 64'd0);
      chk("rstlo_data", 64'(bus.rdata[2*W-1:W]), 64'h0);
      tick(); rst = 1'b1;
      #1 chk("rst_cnt", 64'(bus.pend_cnt), 64'd0);
      chk("rst_err", 64'(bus.sb_err), 64'd0);

      // reservation lost across reset; later load is an error
      reserve(5'd10); tick(); idle();
      rst = 1'b0; tick(); rst = 1'b1;
      bus.we1 = 1'b1; bus.wa1 = 5'd10; bus.wd1 = 32'h77; rav[0] = 5'd10;
      #1 chk("post_busy", 64'(bus.rbusy[0]), 64'd0);
      chk("post_data", 64'(bus.rdata[W-1:0]), 64'h77);
      tick(); idle();
      #1 chk("post_err", 64'(bus.sb_err), 64'd1);
      chk("post_cnt", 64'(bus.pend_cnt), 64'd0);

      for (int c = 0; c < 3000; c++) begin
         rst          = ($urandom_range(0, 59) != 0);
         rav[0]       = rnd_addr();
         rav[1]       = rnd_addr();
         bus.we0      = ($urandom_range(0, 2) == 0);
         bus.wa0      = rnd_addr();
         bus.wd0      = $urandom;
         bus.we1      = ($urandom_range(0, 2) == 0);
         bus.wa1      = rnd_addr();
         bus.wd1      = $urandom;
         bus.rsv_en   = ($urandom_range(0, 2) == 0);
         bus.rsv_addr = rnd_addr();
         tick();
      end
      rst = 1'b1; idle(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/gpr_mp.md
# gpr_mp

Parametrised multi-port general purpose register file with two write ports, NR combinational read ports, write-to-read forwarding, an optional hardwired zero register, and a per-register scoreboard of pending load destinations. It sits between decode (reads, reservations) and the two writeback paths: ALU on port 0, load/memory on port 1. The core's interlock uses it to stall on registers still awaiting load data.

## Interface
- W, default 32: data width.
- AW, default 5: address width; DEPTH = 2**AW entries.
- NR, default 2: number of read ports.
- ZERO_REG, default 1: when 1, entry 0 always reads 0, ignores writes and cannot be reserved.

Ports:
- clk  in  1: clock; all state updates on posedge.
- rst  in  1: synchronous, active-low reset.
- ra  in  NR*AW: read addresses; port i is ra[i*AW +: AW].
- rdata  out  NR*W: read data, combinational; port i is rdata[i*W +: W].
- rbusy  out  NR: per-read-port pending flag, combinational.
- wa0  in  AW: write address, port 0 (ALU).
- wd0  in  W: write data, port 0.
- we0  in  1: write enable, port 0.
- wa1  in  AW: write address, port 1 (load).
- wd1  in  W: write data, port 1.
- we1  in  1: write enable, port 1; also releases the pending bit.
- rsv_en  in  1: reserve request, marks rsv_addr pending.
- rsv_addr  in  AW: register to reserve.
- pend_cnt  out  AW+1: number of pending entries, registered.
- sb_err  out  1: sticky scoreboard error, registered.

## Operation
- Storage: DEPTH x W register array plus a DEPTH-bit pending vector.
- Write: on posedge, if rst high and weN, mem[waN] <= wdN. If we0 && we1 && wa0==wa1, port 1 wins. Writes to entry 0 are dropped when ZERO_REG=1.
- Read port i data:
  - 0 if ZERO_REG && ra_i==0, or if rst is low.
  - Else wd1 if we1 && wa1==ra_i.
  - Else wd0 if we0 && wa0==ra_i.
  - Else mem[ra_i].
- rbusy[i] = pending[ra_i] && !(we1 && wa1==ra_i). Same-cycle release is visible because its data is forwarded. Forced 0 when rst is low.
- Reserve: on posedge with rsv_en, pending[rsv_addr] <= 1.
- Release: on posedge with we1, pending[wa1] <= 0.
- Reserve and release to the same address in one cycle: pending stays 1 (new load supersedes old).
- Ignored reserves:
  - rsv_addr==0 with ZERO_REG=1: no state change.
  - rsv_addr already pending and not released this cycle: pending unchanged; sets sb_err.
- we0 to a pending register (WAW against an outstanding load): write performed, pending unchanged, sets sb_err.
- we1 to a non-pending register: write performed, sets sb_err.
- pend_cnt tracks the population count of pending; incremented and decremented in the same update, never recomputed combinationally from the vector.
- sb_err is sticky and cleared only by reset.

## Timing
- Reset: while rst is low at posedge, all mem entries become 0, pending becomes 0, pend_cnt becomes 0, sb_err becomes 0. Writes and reserves in those cycles are ignored. rdata and rbusy read 0 combinationally while rst is low.
- Read latency 0 (combinational). Write is visible in mem one cycle after we, and same-cycle via forwarding.
- Reserve is visible on rbusy the cycle after rsv_en. Release clears rbusy in the we1 cycle itself.
- pend_cnt and sb_err update one cycle after the causing event.
- Reset mid-operation: in-flight reservations are discarded; a load writeback arriving after reset is treated as a release of a non-pending register and sets sb_err.

## Test plan
- Reset, then read all 32 entries on both ports -> every rdata 0, rbusy 0, pend_cnt 0, sb_err 0.
- we0 wa0=5 wd0=0xDEADBEEF with ra[0]=5 in the same cycle -> rdata[0]=0xDEADBEEF; next cycle with no write -> still 0xDEADBEEF.
- we0 and we1 both target 7 with wd0=1, wd1=2 -> same-cycle read 2, mem[7]=2 afterwards.
- Write 0x1234 to register 0 -> reads 0, pend_cnt 0.
  - rsv_addr=0 -> rbusy 0, pend_cnt 0.
- Reserve 9 -> next cycle rbusy=1, pend_cnt=1.
  - we1 wa1=9 wd1=0x55 -> same cycle rbusy=0, rdata=0x55; next cycle pend_cnt=0, sb_err=0.
- Reserve 3 twice -> sb_err=1 and pend_cnt=1.
  - Reserve and release 4 in the same cycle -> pend_cnt=2, rbusy(4)=1.
  - Drive rst low -> pend_cnt=0, sb_err=0.
